// File: rtl/cmp_pkg.sv
// Shared types for the digit-serial comparator: FSM state encoding and result flags.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } cmp_state_e;

   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } cmp_flags_t;

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit slice magnitude compare; zero latency, no flow control.
module cmp_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   output logic             gt_o,
   output logic             lt_o
);

   assign gt_o = (a_i > b_i);
   assign lt_o = (a_i < b_i);

endmodule

// File: rtl/digit_serial_comparator.sv
// MSB-first digit-serial compare, 1..WIDTH/DIGIT cycles (early exit on first unequal slice); result held until out_ready.
// DIGIT_SERIAL_CMP_SIGNED_EN adds signed_mode (two's complement compare via MSB inversion at capture).
module digit_serial_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [WIDTH-1:0]                 a,
   input  logic [WIDTH-1:0]                 b,
`ifdef DIGIT_SERIAL_CMP_SIGNED_EN
   input  logic                             signed_mode,
`endif
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             a_gt_b,
   output logic                             a_lt_b,
   output logic                             a_eq_b,
   output logic [$clog2(WIDTH/DIGIT):0]     scan_cycles
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int SCW  = $clog2(NDIG) + 1;

   if (!((DIGIT == 1) || (DIGIT == 2) || (DIGIT == 4) || (DIGIT == 8)) ||
       (WIDTH % DIGIT != 0) || (WIDTH < DIGIT) || (WIDTH > 64)) begin : g_param_err
      $error("digit_serial_comparator: illegal WIDTH/DIGIT combination");
   end

   cmp_state_e        state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [SCW-1:0]    cnt_q, cnt_d;
   cmp_flags_t        flags_q, flags_d;

   logic [DIGIT-1:0]  a_sl, b_sl;
   logic              sl_gt, sl_lt;
   logic              last_sl;
   logic              msb_flip;
   logic [WIDTH-1:0]  msb_mask;

`ifdef DIGIT_SERIAL_CMP_SIGNED_EN
   assign msb_flip = signed_mode;
`else
   assign msb_flip = 1'b0;
`endif

   // Flipping the sign bit of both operands maps two's complement order onto unsigned order.
   always_comb begin
      msb_mask          = '0;
      msb_mask[WIDTH-1] = msb_flip;
   end

   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx_q == IDXW'(i)) begin
            a_sl = a_q[i*DIGIT +: DIGIT];
            b_sl = b_q[i*DIGIT +: DIGIT];
         end
      end
   end

   assign last_sl = (idx_q == '0);

   cmp_digit #(
      .DIGIT (DIGIT)
   ) u_cmp_digit (
      .a_i  (a_sl),
      .b_i  (b_sl),
      .gt_o (sl_gt),
      .lt_o (sl_lt)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      flags_d = flags_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a ^ msb_mask;
               b_d     = b ^ msb_mask;
               idx_d   = IDXW'(NDIG - 1);
               cnt_d   = SCW'(1);
               flags_d = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (sl_gt || sl_lt) begin
               flags_d.gt = sl_gt;
               flags_d.lt = sl_lt;
               flags_d.eq = 1'b0;
               state_d    = DONE;
            end else if (last_sl) begin
               flags_d.gt = 1'b0;
               flags_d.lt = 1'b0;
               flags_d.eq = 1'b1;
               state_d    = DONE;
            end else begin
               idx_d = idx_q - IDXW'(1);
               cnt_d = cnt_q + SCW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               flags_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            flags_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         flags_q <= flags_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign a_gt_b      = flags_q.gt;
   assign a_lt_b      = flags_q.lt;
   assign a_eq_b      = flags_q.eq;
   assign scan_cycles = cnt_q;

endmodule

// File: tb/tb_digit_serial_comparator.sv
// Randomized self-checking bench for digit_serial_comparator (WIDTH=16, DIGIT=4) against an arithmetic reference.
module tb_digit_serial_comparator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        sm;
   logic        out_valid;
   logic        out_ready;
   logic        a_gt_b;
   logic        a_lt_b;
   logic        a_eq_b;
   logic [2:0]  scan_cycles;

   int checks   = 0;
   int failures = 0;

   digit_serial_comparator #(
      .WIDTH (16),
      .DIGIT (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
`ifdef DIGIT_SERIAL_CMP_SIGNED_EN
      .signed_mode (sm),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .a_gt_b      (a_gt_b),
      .a_lt_b      (a_lt_b),
      .a_eq_b      (a_eq_b),
      .scan_cycles (scan_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain numeric compare; cycles = 1 + leading equal nibbles (max 4).
   function automatic void model(input logic [15:0] ra, input logic [15:0] rb, input logic rs,
                                 output logic [2:0] fl, output int k);
      logic gt, lt;
      if (rs) begin
         gt = $signed(ra) > $signed(rb);
         lt = $signed(ra) < $signed(rb);
      end else begin
         gt = ra > rb;
         lt = ra < rb;
      end
      fl = {gt, lt, (ra == rb)};
      k  = 1;
      for (int i = 3; i > 0; i--) begin
         if (ra[i*4 +: 4] != rb[i*4 +: 4]) break;
         k++;
      end
   endfunction

   task automatic scramble();
      a  = 16'($urandom);
      b  = 16'($urandom);
      sm = 1'($urandom);
   endtask

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                         input int hold, input bit rand_rdy);
      logic [2:0] fl;
      int         k;
      int         lat;
      model(ta, tb_v, ts, fl, k);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      a        = ta;
      b        = tb_v;
      sm       = ts;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'($urandom);
      scramble();
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (rand_rdy) out_ready = 1'($urandom);
         chk("busy_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
         in_valid = 1'($urandom);
         scramble();
      end
      out_ready = 1'b0;
      chk("latency", 32'(lat), 32'(k));
      chk("scan_cycles", 32'(scan_cycles), 32'(k));
      chk("flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(fl));
      chk("done_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         in_valid = 1'($urandom);
         scramble();
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(fl));
         chk("hold_scan", 32'(scan_cycles), 32'(k));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("post_valid", 32'(out_valid), 32'd0);
      chk("post_in_ready", 32'(in_ready), 32'd1);
      chk("post_flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra, rb;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 16'h0;
      b         = 16'h0;
      sm        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'd0);
      chk("rst_scan", 32'(scan_cycles), 32'd0);
      rst_n = 1'b1;

      // First accept lands on the first edge after release.
      run_op(16'hA000, 16'h9FFF, 1'b0, 0, 1'b0);
      run_op(16'h1234, 16'h1235, 1'b0, 2, 1'b0);
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 10, 1'b0);

      // Reset in the second SCAN cycle abandons the operation.
      a = 16'h1111; b = 16'h1112; sm = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #3;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_scan", 32'(scan_cycles), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("after_rst_valid", 32'(out_valid), 32'd0);
         chk("after_rst_in_ready", 32'(in_ready), 32'd1);
      end

`ifdef DIGIT_SERIAL_CMP_SIGNED_EN
      run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
      run_op(16'hFFFF, 16'h0000, 1'b1, 1, 1'b0);
`endif

      for (int n = 0; n < 300; n++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            scramble();
            @(posedge clk); #1;
         end
         ra = 16'($urandom);
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = ra ^ (16'h1 << $urandom_range(0, 15));
            2: rb = {ra[15:8], 8'($urandom)};
            default: rb = 16'($urandom);
         endcase
`ifdef DIGIT_SERIAL_CMP_SIGNED_EN
         run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'b1);
`else
         run_op(ra, rb, 1'b0, $urandom_range(0, 3), 1'b1);
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
